// File: rtl/fir_output_serializer.sv
// rtl/fir_output_serializer.sv - buffers parallel FIR beats and streams them out one sample per cycle, oldest lane first
// Optional feature macro: FIR_SER_SAMPLE_COUNT_EN (adds the o_sample_cnt pop counter port)

module fir_output_serializer #(
    parameter int NB_OUT      = 18,
    parameter int PARALLELISM = 8,
    parameter int DEPTH       = 2
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_valid,
    input  logic [PARALLELISM*NB_OUT-1:0] i_data,
    output logic                          o_ready,
    output logic [NB_OUT-1:0]             o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_overflow
`ifdef FIR_SER_SAMPLE_COUNT_EN
    ,
    output logic [31:0]                   o_sample_cnt
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(PARALLELISM - 1);

    // Beat storage, split per lane so the read side is a plain two-level index
    logic [NB_OUT-1:0] r_buf [DEPTH][PARALLELISM];

    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LANE_W-1:0] r_lane;
    logic [NB_OUT-1:0] r_hold;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic              w_retire;
    logic [NB_OUT-1:0] w_sample;

    // o_ready depends only on the registered count, never on i_ready, so a
    // beat may be pushed on the same edge that another beat retires.
    assign o_ready    = (r_count != FULL_COUNT);
    assign o_valid    = (r_count != '0) & i_enable;
    assign w_push     = i_enable & i_valid & o_ready;
    assign w_pop      = o_valid & i_ready;
    assign w_retire   = w_pop & (r_lane == LAST_LANE);
    assign w_sample   = r_buf[r_rd_ptr][r_lane];
    // While idle or frozen, o_data repeats the last sample that was presented
    assign o_data     = o_valid ? w_sample : r_hold;
    assign o_overflow = r_overflow;

    // Capture an accepted beat into the slot at the write pointer
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            for (int k = 0; k < PARALLELISM; k++) begin
                r_buf[r_wr_ptr][k] <= i_data[k*NB_OUT +: NB_OUT];
            end
        end
    end

    // Occupancy, pointers, lane walk, held output and sticky overflow
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_lane     <= '0;
            r_hold     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                if (r_lane == LAST_LANE) begin
                    r_lane   <= '0;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end else begin
                    r_lane <= r_lane + 1'b1;
                end
            end

            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (o_valid) begin
                r_hold <= w_sample;
            end

            if (i_enable & i_valid & ~o_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef FIR_SER_SAMPLE_COUNT_EN
    logic [31:0] r_sample_cnt;

    assign o_sample_cnt = r_sample_cnt;

    // Free-running count of delivered samples, wrapping naturally at 2^32
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sample_cnt <= '0;
        end else if (w_pop) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_output_serializer.sv
// tb/tb_fir_output_serializer.sv - self-checking bench for fir_output_serializer

module tb_fir_output_serializer;

    localparam int NB = 18;
    localparam int P  = 8;
    localparam int W  = NB * P;
    localparam int NV = 27;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic          i_valid;
    logic [W-1:0]  i_data;
    logic          o_ready;
    logic [NB-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_overflow;
`ifdef FIR_SER_SAMPLE_COUNT_EN
    logic [31:0]   o_sample_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 i_clock = ~i_clock;

    fir_output_serializer #(.NB_OUT(NB), .PARALLELISM(P), .DEPTH(2)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_overflow (o_overflow)
`ifdef FIR_SER_SAMPLE_COUNT_EN
        ,
        .o_sample_cnt (o_sample_cnt)
`endif
    );

    typedef struct {
        logic          valid;
        logic [W-1:0]  data;
        logic          ready;
        logic          en;
        logic          exp_valid;
        logic [NB-1:0] exp_data;
        logic          exp_ready;
    } vec_t;

    vec_t tbl [NV];

    function automatic logic [NB-1:0] s(input int v);
        logic [31:0] t;
        t = v;
        return t[NB-1:0];
    endfunction

    function automatic logic [W-1:0] ramp(input int base, input int sgn);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < P; k++) begin
            b[k*NB +: NB] = s(sgn * (base + k));
        end
        return b;
    endfunction

    function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r, input logic e,
                                input logic ev, input logic [NB-1:0] ed, input logic er);
        vec_t x;
        x.valid = v; x.data = d; x.ready = r; x.en = e;
        x.exp_valid = ev; x.exp_data = ed; x.exp_ready = er;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge i_clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [W-1:0] d, input logic r, input logic e);
        i_valid  = v;
        i_data   = d;
        i_ready  = r;
        i_enable = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            t2 [P];
        logic [W-1:0]  beat1;
        logic [NB-1:0] exp_q [$];
        int            popped;
        int            c_st;
        int            e_st;
        logic          off_c;
        logic          off_e;

        t2 = '{1, 2, -3, 4, 5, -6, 7, 8};
        beat1 = '0;
        for (int k = 0; k < P; k++) beat1[k*NB +: NB] = s(t2[k]);

        // vectors: single beat, then back-pressure on a second beat
        tbl[0] = mk(1'b1, beat1, 1'b1, 1'b1, 1'b0, s(0), 1'b1);
        for (int r = 1; r <= 8; r++) tbl[r] = mk(1'b0, '0, 1'b1, 1'b1, 1'b1, s(t2[r-1]), 1'b1);
        tbl[9] = mk(1'b0, '0, 1'b1, 1'b1, 1'b0, s(8), 1'b1);
        tbl[10] = mk(1'b1, ramp(10, 1), 1'b0, 1'b1, 1'b0, s(8), 1'b1);
        for (int r = 1; r <= 15; r++)
            tbl[10+r] = mk(1'b0, '0, logic'(r % 2), 1'b1, 1'b1, s(10 + r / 2), 1'b1);
        tbl[26] = mk(1'b0, '0, 1'b1, 1'b1, 1'b0, s(17), 1'b1);

        // reset
        i_reset = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b1);
        repeat (2) next();
        i_reset = 1'b0;
        @(negedge i_clock);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
`ifdef FIR_SER_SAMPLE_COUNT_EN
        chk("rst_cnt", o_sample_cnt, 32'd0);
`endif
        next();

        for (int r = 0; r < NV; r++) begin
            set_in(tbl[r].valid, tbl[r].data, tbl[r].ready, tbl[r].en);
            @(negedge i_clock);
            chk($sformatf("vec%0d_valid", r), 32'(o_valid), 32'(tbl[r].exp_valid));
            chk($sformatf("vec%0d_data", r), 32'(o_data), 32'(tbl[r].exp_data));
            chk($sformatf("vec%0d_ready", r), 32'(o_ready), 32'(tbl[r].exp_ready));
            next();
        end

        // fill to full with i_ready low, then overflow with beat D
        for (int k = 0; k < P; k++) exp_q.push_back(s(100 + k));
        for (int k = 0; k < P; k++) exp_q.push_back(s(200 + k));
        for (int k = 0; k < P; k++) exp_q.push_back(s(-(300 + k)));
        for (int k = 0; k < P; k++) exp_q.push_back(s(400 + k));

        set_in(1'b1, ramp(100, 1), 1'b0, 1'b1);
        @(negedge i_clock);
        chk("t4_ready_a", 32'(o_ready), 32'd1);
        next();
        set_in(1'b1, ramp(200, 1), 1'b0, 1'b1);
        @(negedge i_clock);
        chk("t4_ready_b", 32'(o_ready), 32'd1);
        chk("t4_a0_shown", 32'(o_data), 32'(s(100)));
        next();
        set_in(1'b1, ramp(900, 1), 1'b0, 1'b1);
        @(negedge i_clock);
        chk("t4_full_ready", 32'(o_ready), 32'd0);
        chk("t5_ovf_before", 32'(o_overflow), 32'd0);
        next();
        set_in(1'b0, '0, 1'b0, 1'b1);
        @(negedge i_clock);
        chk("t5_ovf_set", 32'(o_overflow), 32'd1);
        chk("t5_still_full", 32'(o_ready), 32'd0);
        chk("t4_hold_a0", 32'(o_data), 32'(s(100)));
        next();

        // drain with i_ready high; C offered from A lane 7, E at C lane 7
        popped = 0;
        c_st = 0;
        e_st = 0;
        for (int cyc = 0; cyc < 80 && popped < 4 * P; cyc++) begin
            off_c = (popped >= P - 1) && (c_st == 0);
            off_e = (popped >= 3 * P - 1) && (c_st == 1) && (e_st == 0);
            set_in(off_c | off_e, off_c ? ramp(300, -1) : (off_e ? ramp(400, 1) : '0), 1'b1, 1'b1);
            @(negedge i_clock);
            if (popped == P - 1) chk("t4_full_at_a7", 32'(o_ready), 32'd0);
            if (popped == 3 * P - 1) chk("t4_ready_at_c7", 32'(o_ready), 32'd1);
            chk($sformatf("t4_valid%0d", popped), 32'(o_valid), 32'd1);
            if (o_valid) begin
                chk($sformatf("t4_data%0d", popped), 32'(o_data), 32'(exp_q[popped]));
                popped++;
            end
            if (i_valid && o_ready) begin
                if (off_c) c_st = 1;
                if (off_e) e_st = 1;
            end
            next();
        end
        chk("t4_popped", popped, 32'(4 * P));
        set_in(1'b0, '0, 1'b1, 1'b1);
        @(negedge i_clock);
        chk("t5_d_absent", 32'(o_valid), 32'd0);
        chk("t5_ovf_sticky", 32'(o_overflow), 32'd1);
`ifdef FIR_SER_SAMPLE_COUNT_EN
        chk("t4_cnt", o_sample_cnt, 32'd48);
`endif
        next();

        // enable freeze at lane 3
        set_in(1'b1, ramp(500, 1), 1'b1, 1'b1);
        @(negedge i_clock);
        chk("t6_push_ready", 32'(o_ready), 32'd1);
        next();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, '0, 1'b1, 1'b1);
            @(negedge i_clock);
            chk($sformatf("t6_pre_data%0d", k), 32'(o_data), 32'(s(500 + k)));
            next();
        end
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, ramp(600, 1), 1'b1, 1'b0);
            @(negedge i_clock);
            chk($sformatf("t6_frz_valid%0d", k), 32'(o_valid), 32'd0);
            chk($sformatf("t6_frz_ready%0d", k), 32'(o_ready), 32'd1);
            chk($sformatf("t6_frz_ovf%0d", k), 32'(o_overflow), 32'd1);
`ifdef FIR_SER_SAMPLE_COUNT_EN
            chk($sformatf("t6_frz_cnt%0d", k), o_sample_cnt, 32'd51);
`endif
            next();
        end
        for (int k = 3; k < P; k++) begin
            set_in(1'b0, '0, 1'b1, 1'b1);
            @(negedge i_clock);
            chk($sformatf("t6_res_valid%0d", k), 32'(o_valid), 32'd1);
            chk($sformatf("t6_res_data%0d", k), 32'(o_data), 32'(s(500 + k)));
            next();
        end
        @(negedge i_clock);
        chk("t6_no_push", 32'(o_valid), 32'd0);
`ifdef FIR_SER_SAMPLE_COUNT_EN
        chk("t6_cnt", o_sample_cnt, 32'd56);
`endif
        next();

        // reset with two beats buffered
        set_in(1'b1, ramp(700, 1), 1'b0, 1'b1);
        next();
        set_in(1'b1, ramp(800, 1), 1'b0, 1'b1);
        next();
        set_in(1'b0, '0, 1'b0, 1'b1);
        @(negedge i_clock);
        chk("t1_two_buffered", 32'(o_ready), 32'd0);
        i_reset = 1'b1;
        next();
        i_reset = 1'b0;
        @(negedge i_clock);
        chk("t1_valid", 32'(o_valid), 32'd0);
        chk("t1_data", 32'(o_data), 32'd0);
        chk("t1_ready", 32'(o_ready), 32'd1);
        chk("t1_overflow", 32'(o_overflow), 32'd0);
`ifdef FIR_SER_SAMPLE_COUNT_EN
        chk("t1_cnt", o_sample_cnt, 32'd0);
`endif
        next();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, '0, 1'b1, 1'b1);
            @(negedge i_clock);
            chk($sformatf("t1_no_partial%0d", k), 32'(o_valid), 32'd0);
            next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
